// File: rtl/adc_spi_pkg.sv
// -----------------------------------------------------------------------------
// adc_spi_pkg
// Shared definitions for the SPI ADC responder: FSM state encoding, the
// layout of the 6-bit configuration word, reset/flip constants, and the
// channel-select/result-format helper used when a conversion is latched.
// -----------------------------------------------------------------------------
package adc_spi_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CONVERTING = 3'd1,
      READY      = 3'd2,
      SHIFT      = 3'd3,
      DONE       = 3'd4
   } state_t;

   localparam int RESULT_BITS = 12;
   localparam int NUM_CH      = 8;
   localparam int CFG_BITS    = 6;

   // Configuration word layout {S/D, O/S, S1, S0, UNI, SLP}
   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   localparam logic [CFG_BITS-1:0]    RESET_CFG    = 6'b100010;
   localparam logic [RESULT_BITS-1:0] BIPOLAR_FLIP = 12'h800;

   // Channel index is {S1, S0, O/S} for both single-ended and differential.
   function automatic logic [2:0] cfg_channel(input logic [CFG_BITS-1:0] cfg);
      return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
   endfunction

   // Pick the configured channel and convert offset binary to two's
   // complement when bipolar mode is selected.
   function automatic logic [RESULT_BITS-1:0] select_result(
      input logic [CFG_BITS-1:0]           cfg,
      input logic [NUM_CH*RESULT_BITS-1:0] ch_data
   );
      logic [RESULT_BITS-1:0] raw;
      int unsigned            idx;
      idx = 32'(cfg_channel(cfg));
      raw = ch_data[idx*RESULT_BITS +: RESULT_BITS];
      if (cfg[CFG_UNI]) begin
         return raw;
      end else begin
         return raw ^ BIPOLAR_FLIP;
      end
   endfunction

endpackage

// File: rtl/adc_spi_responder_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Multi-stage synchronizer for an asynchronous input followed by registered
// rise/fall pulse generation. Pulses appear STAGES+1 clocks after the pin
// changes. A rise is only reported once a genuine low level has been seen
// after reset, so an input already high at reset release gives no rise.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized level
//   rise, fall : one-clock pulses on synchronized edges
// -----------------------------------------------------------------------------
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic [STAGES-1:0] valid_r;
   logic              prev_r;
   logic              seen_low_r;
   logic              rise_r;
   logic              fall_r;
   logic              synced_s;
   logic              sync_valid_s;

   assign synced_s     = sync_r[STAGES-1];
   assign sync_valid_s = valid_r[STAGES-1];

   // Synchronizer chain, flush tracking and registered edge pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r     <= '0;
         valid_r    <= '0;
         prev_r     <= 1'b0;
         seen_low_r <= 1'b0;
         rise_r     <= 1'b0;
         fall_r     <= 1'b0;
      end else begin
         sync_r     <= STAGES'({sync_r, din});
         valid_r    <= STAGES'({valid_r, 1'b1});
         prev_r     <= synced_s;
         seen_low_r <= seen_low_r | (sync_valid_s & ~synced_s);
         rise_r     <= synced_s & ~prev_r & seen_low_r;
         fall_r     <= ~synced_s & prev_r;
      end
   end

   assign level = synced_s;
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
// Emulates an LTC2308-style SPI ADC toward an FPGA initiator. CONVST rise
// latches the selected channel of ch_data and starts a fixed-length
// conversion; CONVST low then frames a 12-bit MSB-first result on ADC_SDO
// while the first 6 SDI bits are captured as the next configuration word.
// Ports:
//   FPGA_CLK1_50 : system clock          reset_n   : async active-low reset
//   ADC_SCK/ADC_CONVST/ADC_SDI : SPI inputs (asynchronous, synchronized here)
//   ADC_SDO      : result serial output
//   ch_data      : eight 12-bit samples, channel n at [12n+11:12n]
//   cfg_word     : last accepted config  cfg_valid : strobe on cfg update
//   err_early    : strobe when CONVST falls during conversion
//   busy         : high while converting
// -----------------------------------------------------------------------------
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int CONV_CYCLES = 80,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          FPGA_CLK1_50,
   input  logic                          reset_n,
   input  logic                          ADC_SCK,
   input  logic                          ADC_CONVST,
   input  logic                          ADC_SDI,
   output logic                          ADC_SDO,
   input  logic [NUM_CH*RESULT_BITS-1:0] ch_data,
   output logic [CFG_BITS-1:0]           cfg_word,
   output logic                          cfg_valid,
   output logic                          err_early,
   output logic                          busy
);

   localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

   logic sck_level_s, sck_rise_s, sck_fall_s;
   logic cnv_level_s, cnv_rise_s, cnv_fall_s;
   logic sdi_level_s, sdi_rise_s, sdi_fall_s;
   logic unused_ok_s;

   state_t                 state_r, state_next_s;
   logic [CNT_W-1:0]       conv_cnt_r, conv_cnt_next_s;
   logic [RESULT_BITS-1:0] result_r, result_next_s;
   logic [3:0]             bit_cnt_r, bit_cnt_next_s;
   logic [3:0]             out_cnt_r, out_cnt_next_s;
   logic [CFG_BITS-1:0]    cfg_shift_r, cfg_shift_next_s;
   logic [CFG_BITS-1:0]    cfg_word_r, cfg_word_next_s;
   logic                   cfg_valid_r, cfg_valid_next_s;
   logic                   err_early_r, err_early_next_s;
   logic                   early_r, early_next_s;
   logic                   sdo_r, sdo_next_s;
   logic                   busy_r, busy_next_s;
   logic                   start_conv_s, frame_end_s, enter_shift_s;

   edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(FPGA_CLK1_50), .rst_n(reset_n), .din(ADC_SCK),
      .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) u_sync_cnv (
      .clk(FPGA_CLK1_50), .rst_n(reset_n), .din(ADC_CONVST),
      .level(cnv_level_s), .rise(cnv_rise_s), .fall(cnv_fall_s)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk(FPGA_CLK1_50), .rst_n(reset_n), .din(ADC_SDI),
      .level(sdi_level_s), .rise(sdi_rise_s), .fall(sdi_fall_s)
   );

   // S/D and SLP do not alter behaviour; the spare sync outputs are unused
   assign unused_ok_s = &{1'b0, sck_level_s, cnv_level_s, sdi_rise_s, sdi_fall_s,
                          cfg_word_r[CFG_SD], cfg_word_r[CFG_SLP]};

   // Next-state and next-datapath decode for the conversion/shift FSM
   always_comb begin
      state_next_s     = state_r;
      conv_cnt_next_s  = conv_cnt_r;
      result_next_s    = result_r;
      bit_cnt_next_s   = bit_cnt_r;
      out_cnt_next_s   = out_cnt_r;
      cfg_shift_next_s = cfg_shift_r;
      cfg_word_next_s  = cfg_word_r;
      cfg_valid_next_s = 1'b0;
      err_early_next_s = 1'b0;
      early_next_s     = early_r;
      sdo_next_s       = 1'b0;
      start_conv_s     = 1'b0;
      frame_end_s      = 1'b0;
      enter_shift_s    = 1'b0;

      case (state_r)
         IDLE: begin
            if (cnv_rise_s) begin
               start_conv_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         CONVERTING: begin
            if (cnv_fall_s) begin
               err_early_next_s = 1'b1;
               early_next_s     = 1'b1;
            end else begin
               early_next_s = early_r;
            end
            if (conv_cnt_r == CNT_LAST) begin
               // A frame already opened early goes straight to shifting
               if (early_r || cnv_fall_s) begin
                  enter_shift_s = 1'b1;
               end else begin
                  state_next_s = READY;
               end
            end else begin
               conv_cnt_next_s = conv_cnt_r + CNT_W'(1);
            end
         end
         READY: begin
            if (cnv_fall_s) begin
               enter_shift_s = 1'b1;
            end else begin
               state_next_s = READY;
            end
         end
         SHIFT: begin
            if (cnv_rise_s) begin
               frame_end_s = 1'b1;
            end else begin
               if (sck_fall_s && (out_cnt_r < 4'd12)) begin
                  out_cnt_next_s = out_cnt_r + 4'd1;
               end else begin
                  out_cnt_next_s = out_cnt_r;
               end
               if (sck_rise_s) begin
                  if (bit_cnt_r < 4'd6) begin
                     cfg_shift_next_s = {cfg_shift_r[CFG_BITS-2:0], sdi_level_s};
                  end else begin
                     cfg_shift_next_s = cfg_shift_r;
                  end
                  bit_cnt_next_s = bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd11) begin
                     state_next_s = DONE;
                  end else begin
                     state_next_s = SHIFT;
                  end
               end else begin
                  bit_cnt_next_s = bit_cnt_r;
               end
            end
         end
         DONE: begin
            if (cnv_rise_s) begin
               frame_end_s = 1'b1;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase

      if (enter_shift_s) begin
         state_next_s     = SHIFT;
         bit_cnt_next_s   = 4'd0;
         out_cnt_next_s   = 4'd0;
         cfg_shift_next_s = '0;
      end else begin
         cfg_shift_next_s = cfg_shift_next_s;
      end

      // Config update happens first so the new conversion sees it
      if (frame_end_s && (bit_cnt_r >= 4'd6)) begin
         cfg_word_next_s  = cfg_shift_r;
         cfg_valid_next_s = 1'b1;
      end else begin
         cfg_word_next_s  = cfg_word_next_s;
      end

      if (start_conv_s || frame_end_s) begin
         result_next_s   = select_result(cfg_word_next_s, ch_data);
         conv_cnt_next_s = '0;
         early_next_s    = 1'b0;
         state_next_s    = CONVERTING;
      end else begin
         result_next_s   = result_next_s;
      end

      if ((state_next_s == SHIFT) && (out_cnt_next_s < 4'd12)) begin
         sdo_next_s = result_next_s[4'd11 - out_cnt_next_s];
      end else begin
         sdo_next_s = 1'b0;
      end

      busy_next_s = (state_next_s == CONVERTING);
   end

   // State and datapath registers
   always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         conv_cnt_r  <= '0;
         result_r    <= '0;
         bit_cnt_r   <= 4'd0;
         out_cnt_r   <= 4'd0;
         cfg_shift_r <= '0;
         cfg_word_r  <= RESET_CFG;
         cfg_valid_r <= 1'b0;
         err_early_r <= 1'b0;
         early_r     <= 1'b0;
         sdo_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         conv_cnt_r  <= conv_cnt_next_s;
         result_r    <= result_next_s;
         bit_cnt_r   <= bit_cnt_next_s;
         out_cnt_r   <= out_cnt_next_s;
         cfg_shift_r <= cfg_shift_next_s;
         cfg_word_r  <= cfg_word_next_s;
         cfg_valid_r <= cfg_valid_next_s;
         err_early_r <= err_early_next_s;
         early_r     <= early_next_s;
         sdo_r       <= sdo_next_s;
         busy_r      <= busy_next_s;
      end
   end

   assign ADC_SDO   = sdo_r;
   assign cfg_word  = cfg_word_r;
   assign cfg_valid = cfg_valid_r;
   assign err_early = err_early_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_responder
// Drives CONVST/SCK/SDI frames; expected results are pushed to a scoreboard
// queue when each conversion is started and popped when the frame is read.
// -----------------------------------------------------------------------------
module tb_adc_spi_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sck, convst, sdi;
   logic        sdo;
   logic [95:0] ch_data;
   logic [5:0]  cfg_word;
   logic        cfg_valid, err_early, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cv_cnt  = 0;
   int ee_cnt  = 0;

   logic [11:0] exp_q[$];
   logic [5:0]  model_cfg;
   logic [5:0]  pending_cfg;
   bit          pending_ok;

   adc_spi_responder #(.CONV_CYCLES(80), .SYNC_STAGES(2)) dut (
      .FPGA_CLK1_50(clk), .reset_n(reset_n), .ADC_SCK(sck),
      .ADC_CONVST(convst), .ADC_SDI(sdi), .ADC_SDO(sdo),
      .ch_data(ch_data), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
      .err_early(err_early), .busy(busy)
   );

   always #10 clk = ~clk;

   // Count strobes
   always @(posedge clk) begin
      if (reset_n === 1'b1) begin
         if (cfg_valid === 1'b1) cv_cnt++;
         if (err_early === 1'b1) ee_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] model_result(input logic [5:0] c, input logic [95:0] d);
      int          ch;
      logic [11:0] r;
      ch = 32'({c[3], c[2], c[4]});
      r  = d[ch*12 +: 12];
      if (!c[1]) r = r ^ 12'h800;
      return r;
   endfunction

   task automatic start_conv();
      if (pending_ok) model_cfg = pending_cfg;
      pending_ok = 1'b0;
      exp_q.push_back(model_result(model_cfg, ch_data));
      convst = 1'b1;
   endtask

   task automatic shift_frame(input logic [5:0] bits, input int n, output logic [11:0] got);
      got = 12'h000;
      for (int i = 0; i < n; i++) begin
         sdi = (i < 6) ? bits[5-i] : 1'b0;
         tick(8);
         if (i < 12) got[11-i] = sdo;
         sck = 1'b1;
         tick(8);
         sck = 1'b0;
      end
      sdi = 1'b0;
      tick(8);
      if (n >= 6) begin
         pending_cfg = bits;
         pending_ok  = 1'b1;
      end
   endtask

   task automatic pop_check(input string tag, input int n, input logic [11:0] got);
      logic [11:0] e;
      logic [11:0] mask;
      mask = 12'h000;
      for (int i = 0; i < n && i < 12; i++) mask[11-i] = 1'b1;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'(0), 32'(1));
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(got & mask), 32'(e & mask));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sdo"},   32'(sdo),       32'(0));
      check({tag, "_cfg"},   32'(cfg_word),  32'(6'b100010));
      check({tag, "_cv"},    32'(cfg_valid), 32'(0));
      check({tag, "_err"},   32'(err_early), 32'(0));
      check({tag, "_busy"},  32'(busy),      32'(0));
   endtask

   initial begin
      logic [11:0] got;
      int cv0, ee0;
      reset_n = 1'b0; convst = 1'b1; sck = 1'b0; sdi = 1'b0;
      for (int c = 0; c < 8; c++) ch_data[c*12 +: 12] = 12'(12'h200 + 12'(c * 17));
      ch_data[11:0]  = 12'hABC;
      ch_data[23:12] = 12'h123;
      model_cfg = 6'b100010; pending_ok = 1'b0; pending_cfg = 6'b000000;

      tick(3);
      check_reset_outputs("reset");
      reset_n = 1'b1;              // CONVST already high at release
      tick(100);
      check("no_start_high_at_reset", 32'(busy), 32'(0));
      convst = 1'b0;
      tick(10);

      // Frame 1: ch0 single-ended unipolar, send config 100010
      start_conv();
      tick(5);
      check("f1_busy", 32'(busy), 32'(1));
      tick(90);
      check("f1_ready_busy", 32'(busy), 32'(0));
      check("f1_ready_sdo", 32'(sdo), 32'(0));
      convst = 1'b0; tick(10);
      shift_frame(6'b100010, 12, got);
      pop_check("f1_data", 12, got);
      sck = 1'b1; tick(8);
      check("done_sdo_hi", 32'(sdo), 32'(0));
      sck = 1'b0; tick(8);
      check("done_sdo_lo", 32'(sdo), 32'(0));
      cv0 = cv_cnt;
      start_conv();
      tick(8);
      check("f1_cfg_valid", 32'(cv_cnt - cv0), 32'(1));
      check("f1_cfg_word", 32'(cfg_word), 32'(6'b100010));

      // Frame 2: still ch0; sends ch1 unipolar config
      tick(87);
      convst = 1'b0; tick(10);
      shift_frame(6'b110010, 12, got);
      pop_check("f2_data", 12, got);
      cv0 = cv_cnt;
      start_conv();
      tick(8);
      check("f2_cfg_valid", 32'(cv_cnt - cv0), 32'(1));
      check("f2_cfg_word", 32'(cfg_word), 32'(6'b110010));

      // Frame 3: returns ch1; sends ch0 bipolar config
      tick(87);
      convst = 1'b0; tick(10);
      shift_frame(6'b100000, 12, got);
      pop_check("f3_data", 12, got);
      ch_data[11:0] = 12'h7FF;
      start_conv();

      // Frame 4: bipolar ch0, only 4 SCK
      tick(95);
      convst = 1'b0; tick(10);
      shift_frame(6'b100010, 4, got);
      pop_check("f4_partial", 4, got);
      cv0 = cv_cnt;
      start_conv();
      tick(8);
      check("f4_no_cfg_valid", 32'(cv_cnt - cv0), 32'(0));
      check("f4_cfg_kept", 32'(cfg_word), 32'(6'b100000));
      check("f4_busy", 32'(busy), 32'(1));

      // Frame 5: CONVST drops 20 clocks after rise
      ee0 = ee_cnt;
      tick(12);
      convst = 1'b0;
      tick(40);
      check("early_sdo_converting", 32'(sdo), 32'(0));
      check("early_busy", 32'(busy), 32'(1));
      check("early_err_pulse", 32'(ee_cnt - ee0), 32'(1));
      tick(35);
      check("early_busy_done", 32'(busy), 32'(0));
      check("early_msb", 32'(sdo), 32'(1));
      shift_frame(6'b100010, 12, got);
      pop_check("f5_data", 12, got);
      cv0 = cv_cnt;
      start_conv();
      tick(8);
      check("f5_cfg_valid", 32'(cv_cnt - cv0), 32'(1));
      check("f5_cfg_word", 32'(cfg_word), 32'(6'b100010));
      check("early_err_once", 32'(ee_cnt - ee0), 32'(1));

      // Frame 6: reset after 5 SCK
      tick(87);
      convst = 1'b0; tick(10);
      shift_frame(6'b110010, 5, got);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      exp_q.delete();
      model_cfg = 6'b100010; pending_ok = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(10);
      check("post_reset_cfg", 32'(cfg_word), 32'(6'b100010));

      // Frame 7: back to ch0 unipolar defaults
      start_conv();
      tick(95);
      convst = 1'b0; tick(10);
      shift_frame(6'b100010, 12, got);
      pop_check("f7_data", 12, got);
      check("queue_empty", 32'(exp_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
